// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decides each cycle whether PC and stage registers
// advance, hold or take a bubble (load-use, ID redirects, dmem waits with timeout).
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                IF_ID_inst_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic [6:0]                ID_EX_inst_opcode,
  input  logic                      ID_EX_reg_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ack,
  output logic                      pc_wr_en,
  output logic                      IF_ID_wr_en,
  output logic                      IF_ID_flush,
  output logic                      ID_EX_flush,
  output logic                      EX_MEM_wr_en,
  output logic                      MEM_WB_wr_en,
  output logic                      mem_err,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt,
  output logic                      state_dbg
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [7:0]           WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [0:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_set;
  logic       rs1_used, rs2_used, hz, mw, timeout;

  // Only a load in EX can stall; ALU results reach ID through forwarding.
  always_comb begin
    rs1_used = (IF_ID_inst_opcode != OP_JAL);
    rs2_used = (IF_ID_inst_opcode == OP_R_TYPE) || (IF_ID_inst_opcode == OP_SW) ||
               (IF_ID_inst_opcode == OP_BEQ);
    hz = (ID_EX_inst_opcode == OP_LW) && ID_EX_reg_wr_en && (ID_EX_rd != '0) &&
         ((rs1_used && (ID_EX_rd == IF_ID_rs1)) || (rs2_used && (ID_EX_rd == IF_ID_rs2)));
    timeout = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
    mw      = dmem_req && !dmem_ack && !timeout;
  end

  always_comb begin
    pc_wr_en     = 1'b1;
    IF_ID_wr_en  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_wr_en = 1'b1;
    MEM_WB_wr_en = 1'b1;
    if (!rst_n) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_wr_en = 1'b0;
      MEM_WB_wr_en = 1'b0;
    end else if (mw) begin
      pc_wr_en     = 1'b0;
      IF_ID_wr_en  = 1'b0;
      EX_MEM_wr_en = 1'b0;
      MEM_WB_wr_en = 1'b0;
    end else if (hz) begin
      // Branch operands are not valid yet, so the redirect re-resolves next cycle.
      pc_wr_en    = 1'b0;
      IF_ID_wr_en = 1'b0;
      ID_EX_flush = 1'b1;
    end else begin
      IF_ID_flush = branch_taken;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mw) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          err_set      = timeout;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) mem_err <= 1'b1;
      if (!pc_wr_en && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (IF_ID_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign state_dbg = state[0];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: control vectors queued as expected, checked each cycle,
// plus counter/error checks; a CNT_WIDTH=4 copy shares inputs for saturation.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  // {pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, EX_MEM_wr_en, MEM_WB_wr_en}
  localparam logic [5:0] V_NORM = 6'b110011;
  localparam logic [5:0] V_BR   = 6'b111011;
  localparam logic [5:0] V_HZ   = 6'b000111;
  localparam logic [5:0] V_MW   = 6'b000000;
  localparam logic [5:0] V_RST  = 6'b001100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] ifid_op, idex_op;
  logic [4:0] rs1, rs2, rd;
  logic       wr_en, br, req, ack;

  logic        pc0, ifwr0, iffl0, idfl0, exwr0, mbwr0, err0, st0;
  logic [31:0] stall0, flush0;
  logic        pc1, ifwr1, iffl1, idfl1, exwr1, mbwr1, err1, st1;
  logic [3:0]  stall1, flush1;
  logic [5:0]  ctrl0;

  int n_assert = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  assign ctrl0 = {pc0, ifwr0, iffl0, idfl0, exwr0, mbwr0};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .MEM_TIMEOUT(16)) u0 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_inst_opcode(ifid_op), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_EX_inst_opcode(idex_op), .ID_EX_reg_wr_en(wr_en), .ID_EX_rd(rd),
    .branch_taken(br), .dmem_req(req), .dmem_ack(ack),
    .pc_wr_en(pc0), .IF_ID_wr_en(ifwr0), .IF_ID_flush(iffl0), .ID_EX_flush(idfl0),
    .EX_MEM_wr_en(exwr0), .MEM_WB_wr_en(mbwr0), .mem_err(err0),
    .stall_cnt(stall0), .flush_cnt(flush0), .state_dbg(st0)
  );

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4), .MEM_TIMEOUT(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_inst_opcode(ifid_op), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
    .ID_EX_inst_opcode(idex_op), .ID_EX_reg_wr_en(wr_en), .ID_EX_rd(rd),
    .branch_taken(br), .dmem_req(req), .dmem_ack(ack),
    .pc_wr_en(pc1), .IF_ID_wr_en(ifwr1), .IF_ID_flush(iffl1), .ID_EX_flush(idfl1),
    .EX_MEM_wr_en(exwr1), .MEM_WB_wr_en(mbwr1), .mem_err(err1),
    .stall_cnt(stall1), .flush_cnt(flush1), .state_dbg(st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op_id, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] op_ex, input logic we, input logic [4:0] d,
                       input logic b, input logic rq, input logic ak);
    ifid_op = op_id; rs1 = r1; rs2 = r2;
    idex_op = op_ex; wr_en = we; rd = d;
    br = b; req = rq; ack = ak;
  endtask

  task automatic idle();
    drive(OP_ADDI, 5'd0, 5'd0, OP_ADDI, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs are driven just after a rising edge; control is sampled on the falling edge.
  task automatic cycle(input string tag, input logic [5:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, 32'(ctrl0), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    cycle("rst_ctrl", V_RST);
    check("rst_stall", stall0, 32'd0);
    check("rst_flush", flush0, 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_state", 32'(st0), 32'd0);
    rst_n = 1'b1;
    cycle("idle", V_NORM);

    // Load-use hazards
    drive(OP_R_TYPE, 5'd5, 5'd7, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cycle("lu_rs1", V_HZ);
    check("lu_stall1", stall0, 32'd1);
    drive(OP_R_TYPE, 5'd5, 5'd7, OP_ADDI, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle("lu_bubble", V_NORM);
    check("lu_stall_hold", stall0, 32'd1);
    drive(OP_R_TYPE, 5'd1, 5'd5, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lu_rs2", V_HZ);
    drive(OP_SW, 5'd9, 5'd5, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lu_sw_rs2", V_HZ);
    check("lu_stall3", stall0, 32'd3);

    // Cases that must not stall
    drive(OP_R_TYPE, 5'd0, 5'd0, OP_LW, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("lw_x0", V_NORM);
    drive(OP_JAL, 5'd5, 5'd5, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lw_jal", V_NORM);
    drive(OP_ADDI, 5'd1, 5'd5, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("addi_rs2_field", V_NORM);
    drive(OP_R_TYPE, 5'd5, 5'd5, OP_R_TYPE, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("alu_forward", V_NORM);
    drive(OP_R_TYPE, 5'd5, 5'd5, OP_LW, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    cycle("lw_no_wr", V_NORM);
    check("nostall_cnt", stall0, 32'd3);

    // Branch redirects
    drive(OP_BEQ, 5'd1, 5'd2, OP_ADDI, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    cycle("br_flush", V_BR);
    check("br_flush_cnt1", flush0, 32'd1);
    drive(OP_BEQ, 5'd1, 5'd5, OP_LW, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle("br_hz", V_HZ);
    check("br_hz_flush_cnt", flush0, 32'd1);
    check("br_hz_stall_cnt", stall0, 32'd4);
    drive(OP_BEQ, 5'd1, 5'd5, OP_ADDI, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle("br_resolve", V_BR);
    check("br_flush_cnt2", flush0, 32'd2);
    drive(OP_JALR, 5'd5, 5'd0, OP_LW, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle("jalr_hz", V_HZ);
    idle();
    cycle("idle2", V_NORM);

    // Data memory waits
    drive(OP_ADDI, 5'd0, 5'd0, OP_ADDI, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle("ack_same", V_NORM);
    check("ack_same_state", 32'(st0), 32'd0);
    drive(OP_ADDI, 5'd0, 5'd0, OP_ADDI, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle("mw1", V_MW);
    check("mw_state", 32'(st0), 32'd1);
    drive(OP_R_TYPE, 5'd5, 5'd7, OP_LW, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle("mw2_hz_br", V_MW);
    cycle("mw3_hz_br", V_MW);
    drive(OP_R_TYPE, 5'd5, 5'd7, OP_LW, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    cycle("mw_release_hz", V_HZ);
    check("mw_ret_state", 32'(st0), 32'd0);
    check("mw_err", 32'(err0), 32'd0);
    check("mw_stall_cnt", stall0, 32'd9);
    check("mw_flush_cnt", flush0, 32'd2);
    idle();
    cycle("idle3", V_NORM);

    // Timeout: 15 frozen cycles, release on the 16th
    drive(OP_ADDI, 5'd0, 5'd0, OP_ADDI, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cycle("to_wait", V_MW);
    check("to_err_pre", 32'(err0), 32'd0);
    check("to_state_pre", 32'(st0), 32'd1);
    cycle("to_release", V_NORM);
    check("to_err", 32'(err0), 32'd1);
    check("to_state", 32'(st0), 32'd0);
    check("to_stall_cnt", stall0, 32'd24);
    idle();
    cycle("idle4", V_NORM);
    check("err_sticky", 32'(err0), 32'd1);

    // Reset in the middle of a wait
    drive(OP_ADDI, 5'd0, 5'd0, OP_ADDI, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    cycle("rw1", V_MW);
    cycle("rw2", V_MW);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'(ctrl0), 32'(V_RST));
    check("rst_mid_state", 32'(st0), 32'd0);
    check("rst_mid_err", 32'(err0), 32'd0);
    check("rst_mid_stall", stall0, 32'd0);
    check("rst_mid_flush", flush0, 32'd0);
    cycle("rst_hold", V_RST);
    rst_n = 1'b1;

    // Saturation of the 4-bit counter copy
    drive(OP_R_TYPE, 5'd5, 5'd7, OP_LW, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("sat_hz", V_HZ);
    check("sat_stall32", stall0, 32'd20);
    check("sat_stall4", 32'(stall1), 32'd15);
    check("sat_flush4", 32'(flush1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32 core. It decides each cycle whether the PC and pipeline registers advance, hold or take a bubble. It covers load-use hazards, branch/jump redirects resolved in ID and multi-cycle data-memory waits with a timeout. It also keeps saturating stall/flush performance counters. It works alongside the forwarding unit: anything the forwarding paths can cover is not stalled here.

## Interface
- REG_ADDR_WIDTH, default `REG_ADDR_WIDTH` (5): register address width.
- CNT_WIDTH, default 32: width of performance counters.
- MEM_TIMEOUT, default 16: maximum dmem wait cycles before forced release; legal range 2..255.

- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IF_ID_inst_opcode  input  7  opcode of the instruction in ID.
- IF_ID_rs1 / IF_ID_rs2  input  REG_ADDR_WIDTH  source registers of the instruction in ID.
- ID_EX_inst_opcode  input  7  opcode of the instruction in EX.
- ID_EX_reg_wr_en  input  1  EX instruction writes the register file.
- ID_EX_rd  input  REG_ADDR_WIDTH  destination of the EX instruction.
- branch_taken  input  1  ID-stage redirect: taken `BEQ`, `JAL` or `JALR`.
- dmem_req  input  1  MEM-stage instruction is accessing data memory (`LW`/`SW`).
- dmem_ack  input  1  data memory completes the access this cycle.
- pc_wr_en  output  1  PC update enable.
- IF_ID_wr_en  output  1  IF/ID register enable.
- IF_ID_flush  output  1  IF/ID register is loaded with a NOP.
- ID_EX_flush  output  1  ID/EX register is loaded with a bubble (all write enables 0).
- EX_MEM_wr_en / MEM_WB_wr_en  output  1  stage register enables.
- mem_err  output  1  sticky: a dmem access timed out.
- stall_cnt  output  CNT_WIDTH  cycles with pc_wr_en=0, saturating.
- flush_cnt  output  CNT_WIDTH  cycles with IF_ID_flush=1, saturating.

## Operation
- FSM states: RUN, MEM_WAIT. Reset state is RUN. Wait counter wait_cnt is 8 bits.
- Hazard detection (hz) is combinational:
  - The EX instruction is `LW`, ID_EX_reg_wr_en=1 and ID_EX_rd!=0.
  - ID_EX_rd matches IF_ID_rs1 (any opcode except `JAL`), or matches IF_ID_rs2 (opcode `R_TYPE`, `SW` or `BEQ` only).
  - This covers both load-use and a branch depending on a load in EX.
  - ALU-result dependences never stall; they are forwarded.
- Memory wait: mw = dmem_req & ~dmem_ack & ~timeout, where timeout = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
- Output priority, highest first:
  - mw: all wr_en=0, both flushes=0. The whole pipeline freezes and branch_taken is ignored.
  - hz: pc_wr_en=0, IF_ID_wr_en=0, ID_EX_flush=1, IF_ID_flush=0, EX_MEM_wr_en=MEM_WB_wr_en=1. branch_taken is ignored because operands are not valid yet.
  - Otherwise: all wr_en=1, ID_EX_flush=0, IF_ID_flush=branch_taken.
- Transitions:
  - RUN to MEM_WAIT when dmem_req & ~dmem_ack; wait_cnt<=1.
  - MEM_WAIT stays while mw; wait_cnt increments.
  - MEM_WAIT to RUN on dmem_ack, or on timeout. Timeout sets mem_err<=1; the pipeline advances that cycle with undefined load data.
- mem_err is cleared only by reset.
- Counters increment by 1 in any cycle with rst_n=1 and the corresponding condition, and hold at 2^CNT_WIDTH-1.

## Timing
- Control outputs are combinational from state, wait_cnt and inputs, and valid in the same cycle. State, wait_cnt, mem_err and counters are registered.
- While rst_n=0 (asynchronous):
  - pc_wr_en, IF_ID_wr_en, EX_MEM_wr_en and MEM_WB_wr_en are 0.
  - IF_ID_flush and ID_EX_flush are 1.
  - mem_err=0, stall_cnt=0, flush_cnt=0, state=RUN, wait_cnt=0.
- The first cycle after deassertion evaluates normally.
- Load-use costs exactly 1 stall cycle; the next cycle the bubble in EX clears hz.
- A taken redirect costs 1 flush cycle.
- dmem with ack in cycle N after req: freeze for N cycles. Ack in the req cycle means no stall.
- Timeout: at most MEM_TIMEOUT-1 frozen cycles, then release.
- Simultaneous events:
  - mw and hz: mw wins; hz is re-evaluated after release.
  - hz and branch_taken: no flush; the branch re-resolves next cycle.
  - Reset mid-MEM_WAIT: immediate return to RUN, counters cleared.

## Test plan
- `LW x5` in EX with `ADD x6,x5,x7` in ID, dmem_ack tied 1 -> one cycle with pc_wr_en=0, ID_EX_flush=1; stall_cnt=1; next cycle all enables 1.
- `LW x0` in EX with ID reading x0, and separately `LW x5` followed by `JAL` -> no stall in either case.
- Taken `BEQ` in ID with no hazard -> IF_ID_flush=1 for 1 cycle, flush_cnt=1. Same `BEQ` depending on `LW` in EX -> 1 stall with no flush, then 1 flush cycle.
- dmem_req=1 with dmem_ack arriving 3 cycles later -> all wr_en=0 for 3 cycles, state returns to RUN, mem_err=0, stall_cnt=3.
- dmem_req=1 with no ack, MEM_TIMEOUT=16 -> 15 frozen cycles, release on the 16th, mem_err=1 and sticky. Assert rst_n=0 mid-wait -> all outputs take reset values immediately.
- CNT_WIDTH=4 with 20 consecutive stall cycles -> stall_cnt saturates at 15.
